// File: rtl/dcache_pkg.sv
// Shared field widths and FSM state type for the 2-way data-cache controller.
package dcache_pkg;

   localparam int ADDR_W    = 32;
   localparam int LINE_W    = 256;
   localparam int TAG_W     = 25;
   localparam int WORD_W    = 32;
   localparam int OFS_W     = 5;
   localparam int IDX_W     = 4;
   localparam int ATAG_W    = 23;
   localparam int WSEL_W    = 3;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU, cache-SRAM and off-chip memory signals of the data-cache controller.
// master = controller side, slave = CPU/SRAM/memory side.
interface dcache_controller_if;
   import dcache_pkg::*;

   logic [ADDR_W-1:0] cpu_addr_i;
   logic [WORD_W-1:0] cpu_data_i;
   logic              cpu_MemRead_i;
   logic              cpu_MemWrite_i;
   logic [WORD_W-1:0] cpu_data_o;
   logic              cpu_stall_o;

   logic [IDX_W-1:0]  sram_addr_o;
   logic [TAG_W-1:0]  sram_tag_o;
   logic [LINE_W-1:0] sram_data_o;
   logic              sram_enable_o;
   logic              sram_write_o;
   logic [TAG_W-1:0]  sram_tag_i;
   logic [LINE_W-1:0] sram_data_i;
   logic              sram_hit_i;

   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;

   modport master (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output cpu_data_o, cpu_stall_o,
      output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      input  sram_tag_i, sram_data_i, sram_hit_i,
      output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
      input  mem_data_i, mem_ack_i
   );

   modport slave (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  cpu_data_o, cpu_stall_o,
      input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      output sram_tag_i, sram_data_i, sram_hit_i,
      input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
      output mem_data_i, mem_ack_i
   );

endinterface

// File: rtl/dcache_word_sel.sv
// Extracts one 32-bit word from a 256-bit cache line and builds the line
// with that word replaced by store data.
module dcache_word_sel
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line,
   input  logic [WSEL_W-1:0] sel,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] word,
   output logic [LINE_W-1:0] merged
);

   logic [7:0] bit_ofs;

   always_comb begin
      bit_ofs = {sel, 5'b0};
      word    = line[bit_ofs +: WORD_W];
      merged  = line;
      merged[bit_ofs +: WORD_W] = wdata;
   end

endmodule

// File: rtl/dcache_controller.sv
// Data-cache miss/hit controller between the CPU MEM stage and data memory.
// Build option DCACHE_STAT_EN adds saturating hit/miss counters on hit_cnt_o/miss_cnt_o.
//
// state      | meaning
// IDLE       | serve hits combinationally, detect misses
// MISS       | inspect LRU victim, latch it if valid and dirty
// WRITEBACK  | write latched dirty victim line to memory
// READMISS   | read requested line, fill SRAM on ack
// READMISSOK | one cycle for the SRAM fill to settle
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   dcache_controller_if.master bus
`ifdef DCACHE_STAT_EN
   ,
   output logic [31:0]         hit_cnt_o,
   output logic [31:0]         miss_cnt_o
`endif
);

   state_e state_q, state_d;

   logic [ADDR_W-1:0] wb_addr_q;
   logic [LINE_W-1:0] wb_data_q;

   logic              req;
   logic              is_wr;
   logic              victim_dirty;
   logic [IDX_W-1:0]  idx;
   logic [ATAG_W-1:0] atag;
   logic [WSEL_W-1:0] wsel;
   logic [WORD_W-1:0] rd_word;
   logic [LINE_W-1:0] merged_line;
   logic              unused_byte_ofs;

   assign req             = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign is_wr           = bus.cpu_MemWrite_i;
   assign idx             = bus.cpu_addr_i[OFS_W+IDX_W-1:OFS_W];
   assign atag            = bus.cpu_addr_i[ADDR_W-1:OFS_W+IDX_W];
   assign wsel            = bus.cpu_addr_i[OFS_W-1:2];
   assign victim_dirty    = bus.sram_tag_i[VALID_BIT] & bus.sram_tag_i[DIRTY_BIT];
   assign bus.sram_addr_o = idx;
   assign unused_byte_ofs = ^bus.cpu_addr_i[1:0];

   dcache_word_sel u_word_sel (
      .line   (bus.sram_data_i),
      .sel    (wsel),
      .wdata  (bus.cpu_data_i),
      .word   (rd_word),
      .merged (merged_line)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == MISS && victim_dirty) begin
            wb_addr_q <= {bus.sram_tag_i[ATAG_W-1:0], idx, {OFS_W{1'b0}}};
            wb_data_q <= bus.sram_data_i;
         end
      end
   end

   always_comb begin
      state_d           = state_q;
      bus.cpu_data_o    = '0;
      bus.sram_write_o  = 1'b0;
      bus.sram_tag_o    = '0;
      bus.sram_data_o   = '0;
      bus.mem_enable_o  = 1'b0;
      bus.mem_write_o   = 1'b0;
      bus.mem_addr_o    = '0;
      bus.mem_data_o    = '0;

      case (state_q)
         IDLE: begin
            if (req && bus.sram_hit_i) begin
               if (is_wr) begin
                  bus.sram_write_o = 1'b1;
                  bus.sram_data_o  = merged_line;
                  bus.sram_tag_o   = {1'b1, 1'b1, atag};
               end else begin
                  bus.cpu_data_o = rd_word;
               end
            end else if (req) begin
               state_d = MISS;
            end
         end
         MISS: begin
            state_d = victim_dirty ? WRITEBACK : READMISS;
         end
         WRITEBACK: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = wb_addr_q;
            bus.mem_data_o   = wb_data_q;
            if (bus.mem_ack_i) state_d = READMISS;
         end
         READMISS: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = {bus.cpu_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            if (bus.mem_ack_i) begin
               bus.sram_write_o = 1'b1;
               bus.sram_data_o  = bus.mem_data_i;
               bus.sram_tag_o   = {1'b1, 1'b0, atag};
               state_d          = READMISSOK;
            end
         end
         READMISSOK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      bus.sram_enable_o = req | (state_q != IDLE);
      bus.cpu_stall_o   = (req & ~bus.sram_hit_i & (state_q == IDLE)) | (state_q != IDLE);

      // Request-driven outputs would otherwise follow the CPU while reset is held.
      if (!rst_i) begin
         bus.cpu_data_o    = '0;
         bus.cpu_stall_o   = 1'b0;
         bus.sram_enable_o = 1'b0;
         bus.sram_write_o  = 1'b0;
         bus.sram_tag_o    = '0;
         bus.sram_data_o   = '0;
         bus.mem_enable_o  = 1'b0;
         bus.mem_write_o   = 1'b0;
         bus.mem_addr_o    = '0;
         bus.mem_data_o    = '0;
      end
   end

`ifdef DCACHE_STAT_EN
   logic hit_evt;
   logic miss_evt;

   assign hit_evt  = (state_q == IDLE) & req & bus.sram_hit_i;
   assign miss_evt = (state_q == IDLE) & req & ~bus.sram_hit_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (hit_evt && (hit_cnt_o != '1)) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (miss_evt && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule
